// File: rtl/uncache_wbuf_pkg.sv
// Shared types and constants for the uncached posted-write buffer.
// FSM encodings and the layout of a buffered store entry.
package uncache_wbuf_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  localparam int ENTRY_W = 68;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Register-array FIFO holding posted uncached stores.
// DEPTH must be a power of two so pointers wrap by natural overflow.
module wbuf_fifo
  import uncache_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  wbuf_entry_t       push_data,
  input  logic              pop,
  output wbuf_entry_t       head,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  wbuf_entry_t        mem_q [DEPTH];
  wbuf_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               push_ok, pop_ok;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[tail_q] = push_data;
      tail_d        = tail_q + 1'b1;
    end
    if (pop_ok) begin
      head_d = head_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[head_q];
  assign count = count_q;
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/uncache_wbuf.sv
// Posted-write buffer between uncache and axi_ctrl: stores are queued and
// retired one at a time; loads wait until every earlier store has retired.
module uncache_wbuf
  import uncache_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        up_wr_req,
  input  logic [3:0]  up_wr_wstrb,
  input  logic [31:0] up_wr_addr,
  input  logic [31:0] up_wr_data,
  output logic        up_wr_ready,
  input  logic        up_rd_req,
  input  logic [31:0] up_rd_addr,
  output logic        up_reload,
  output logic [31:0] up_rd_data,
  output logic        dn_wr_req,
  output logic [3:0]  dn_wr_wstrb,
  output logic [31:0] dn_wr_addr,
  output logic [31:0] dn_wr_data,
  output logic        dn_rd_req,
  output logic [31:0] dn_rd_addr,
  input  logic        dn_reload,
  input  logic [31:0] dn_rd_data,
  output logic        empty
);

  logic [1:0]      state_q, state_d;
  logic [31:0]     rd_addr_q, rd_addr_d;
  wbuf_entry_t     wr_entry;
  wbuf_entry_t     head;
  logic [PTR_W:0]  count;
  logic            full, fifo_empty;
  logic            push, pop, has_entries;

  assign wr_entry    = '{wstrb: up_wr_wstrb, addr: up_wr_addr, data: up_wr_data};
  assign push        = up_wr_req & ~full;
  assign pop         = (state_q == ST_WR) & dn_reload;
  assign has_entries = (count != '0);

  wbuf_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (fifo_empty)
  );

  // A same-cycle push also wakes IDLE so a lone store issues the next cycle;
  // stores always win over a pending load to keep MMIO ordering.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (has_entries || push) begin
          state_d = ST_WR;
        end else if (up_rd_req) begin
          state_d   = ST_RD;
          rd_addr_d = up_rd_addr;
        end
      end
      ST_WR: begin
        if (dn_reload) state_d = ST_IDLE;
      end
      ST_RD: begin
        if (dn_reload) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign up_wr_ready = ~full;
  assign dn_wr_req   = (state_q == ST_WR);
  assign dn_wr_wstrb = head.wstrb;
  assign dn_wr_addr  = head.addr;
  assign dn_wr_data  = head.data;
  assign dn_rd_req   = (state_q == ST_RD);
  assign dn_rd_addr  = rd_addr_q;
  assign up_reload   = (state_q == ST_RD) & dn_reload;
  assign up_rd_data  = dn_rd_data;
  assign empty       = fifo_empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_uncache_wbuf.sv
// Self-checking bench for uncache_wbuf: directed scenarios plus a random
// phase, all checked against a queue-based model of the posted stores.
module tb_uncache_wbuf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        upWrReq = 1'b0;
  logic [3:0]  upWrWstrb = '0;
  logic [31:0] upWrAddr = '0;
  logic [31:0] upWrData = '0;
  logic        upWrReady;
  logic        upRdReq = 1'b0;
  logic [31:0] upRdAddr = '0;
  logic        upReload;
  logic [31:0] upRdData;
  logic        dnWrReq;
  logic [3:0]  dnWrWstrb;
  logic [31:0] dnWrAddr;
  logic [31:0] dnWrData;
  logic        dnRdReq;
  logic [31:0] dnRdAddr;
  logic        dnReload = 1'b0;
  logic [31:0] dnRdData = '0;
  logic        empty;

  uncache_wbuf #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .up_wr_req   (upWrReq),
    .up_wr_wstrb (upWrWstrb),
    .up_wr_addr  (upWrAddr),
    .up_wr_data  (upWrData),
    .up_wr_ready (upWrReady),
    .up_rd_req   (upRdReq),
    .up_rd_addr  (upRdAddr),
    .up_reload   (upReload),
    .up_rd_data  (upRdData),
    .dn_wr_req   (dnWrReq),
    .dn_wr_wstrb (dnWrWstrb),
    .dn_wr_addr  (dnWrAddr),
    .dn_wr_data  (dnWrData),
    .dn_rd_req   (dnRdReq),
    .dn_rd_addr  (dnRdAddr),
    .dn_reload   (dnReload),
    .dn_rd_data  (dnRdData),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cycleIdx = 0;
  logic [67:0] expQ[$];
  logic        loadPending = 1'b0;
  logic [31:0] loadAddr = '0;
  logic        prevRdReq = 1'b0;

  task automatic checkOutput(input string tag, input logic [67:0] observed, input logic [67:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycleIdx);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; loads come from the model.
  task automatic applyStimulus(input logic wr, input logic [3:0] strb, input logic [31:0] addr,
                               input logic [31:0] data, input logic reload, input logic [31:0] rdData);
    upWrReq   = wr;
    upWrWstrb = strb;
    upWrAddr  = addr;
    upWrData  = data;
    upRdReq   = loadPending;
    upRdAddr  = loadAddr;
    dnReload  = reload;
    dnRdData  = rdData;
    #1;
  endtask

  // Reference model: an in-order queue of stores not yet acknowledged downstream.
  task automatic modelCycle();
    logic accept;
    accept = upWrReq && (expQ.size() != DEPTH);
    checkOutput("wr_ready", upWrReady, expQ.size() != DEPTH);
    checkOutput("wr_unexpected", dnWrReq && (expQ.size() == 0), 0);
    if (dnWrReq && expQ.size() != 0)
      checkOutput("wr_head", {dnWrWstrb, dnWrAddr, dnWrData}, expQ[0]);
    checkOutput("rd_wr_exclusive", dnWrReq & dnRdReq, 0);
    checkOutput("rd_unrequested", dnRdReq & ~loadPending, 0);
    if (dnRdReq && !prevRdReq) checkOutput("rd_order", expQ.size(), 0);
    if (dnRdReq) checkOutput("rd_addr", dnRdAddr, loadAddr);
    checkOutput("up_reload", upReload, dnReload & dnRdReq & loadPending);
    if (upReload) checkOutput("up_rd_data", upRdData, dnRdData);
    if (expQ.size() != 0) checkOutput("empty_busy", empty, 0);
    prevRdReq = dnRdReq;
    if (dnReload && dnWrReq && expQ.size() != 0) void'(expQ.pop_front());
    if (accept) expQ.push_back({upWrWstrb, upWrAddr, upWrData});
    if (dnReload && dnRdReq) loadPending = 1'b0;
  endtask

  task automatic endCycle();
    modelCycle();
    @(negedge clk);
    cycleIdx++;
  endtask

  task automatic drainAll(input string tag);
    for (int n = 0; n < 100 && (expQ.size() != 0 || loadPending); n++) begin
      applyStimulus(0, 4'h0, 32'h0, 32'h0, dnWrReq | dnRdReq, $urandom);
      endCycle();
    end
    checkOutput({tag, "_drained"}, (expQ.size() == 0) && !loadPending, 1);
    checkOutput({tag, "_empty"}, empty, 1);
  endtask

  initial begin
    int writesDone, lastWrCycle, firstRd, iter;
    logic reload, wrNow, rdNow;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_wr_ready", upWrReady, 1);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_dn_wr_req", dnWrReq, 0);
    checkOutput("rst_dn_rd_req", dnRdReq, 0);
    checkOutput("rst_up_reload", upReload, 0);
    checkOutput("rst_dn_rd_addr", dnRdAddr, 0);
    checkOutput("rst_dn_wr_fields", {dnWrWstrb, dnWrAddr, dnWrData}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single store: one-cycle issue latency, retire after a delayed ack
    applyStimulus(1, 4'hf, 32'h1faf_f000, 32'hdead_beef, 0, 0);
    endCycle();
    checkOutput("t1_latency", dnWrReq, 1);
    checkOutput("t1_fields", {dnWrWstrb, dnWrAddr, dnWrData}, {4'hf, 32'h1faf_f000, 32'hdead_beef});
    for (int n = 0; n < 2; n++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      endCycle();
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    endCycle();
    checkOutput("t1_wr_req_drop", dnWrReq, 0);
    checkOutput("t1_empty", empty, 1);

    // Fill: five back-to-back stores into four entries
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 4'h1 << (i % 4), 32'h1faf_f100 + 4 * i, 32'h5000_0000 + i, 0, 0);
      endCycle();
    end
    for (int n = 0; n < 2; n++) begin
      applyStimulus(1, 4'hc, 32'h1faf_f110, 32'h5000_0004, 0, 0);
      checkOutput("t2_full_stall", upWrReady, 0);
      endCycle();
    end
    applyStimulus(1, 4'hc, 32'h1faf_f110, 32'h5000_0004, 1, 0);
    checkOutput("t2_no_lookahead", upWrReady, 0);
    endCycle();
    applyStimulus(1, 4'hc, 32'h1faf_f110, 32'h5000_0004, 0, 0);
    checkOutput("t2_ready_after_pop", upWrReady, 1);
    endCycle();
    drainAll("t2");

    // Ordering: a load waits for both earlier stores to retire
    applyStimulus(1, 4'hf, 32'h1faf_f000, 32'h1111_1111, 0, 0);
    endCycle();
    applyStimulus(1, 4'h3, 32'h1faf_f004, 32'h2222_2222, 0, 0);
    endCycle();
    loadPending = 1'b1;
    loadAddr    = 32'h1faf_f008;
    writesDone  = 0;
    lastWrCycle = -100;
    firstRd     = -1;
    for (int n = 0; n < 40 && loadPending; n++) begin
      wrNow = dnWrReq;
      rdNow = dnRdReq;
      if (rdNow && firstRd < 0) begin
        firstRd = cycleIdx;
        checkOutput("t3_writes_before_read", writesDone, 2);
        checkOutput("t3_read_latency", firstRd - lastWrCycle, 2);
      end
      reload = wrNow | rdNow;
      applyStimulus(0, 0, 0, 0, reload, rdNow ? 32'h1234_5678 : $urandom);
      if (rdNow) begin
        checkOutput("t3_up_reload", upReload, 1);
        checkOutput("t3_up_rd_data", upRdData, 32'h1234_5678);
      end
      if (wrNow) begin
        writesDone++;
        lastWrCycle = cycleIdx;
      end
      endCycle();
    end
    checkOutput("t3_load_done", loadPending, 0);

    // Simultaneous push and pop at two entries, wrapping the pointers
    applyStimulus(1, 4'h1, 32'h1faf_f200, 32'ha000_0000, 0, 0);
    endCycle();
    applyStimulus(1, 4'h2, 32'h1faf_f204, 32'ha000_0001, 0, 0);
    endCycle();
    iter = 0;
    for (int n = 0; n < 60 && iter < 10; n++) begin
      if (dnWrReq) begin
        applyStimulus(1, 4'(iter), 32'h1faf_f208 + 4 * iter, 32'ha000_0002 + iter, 1, 0);
        iter++;
      end else begin
        applyStimulus(0, 0, 0, 0, 0, 0);
      end
      endCycle();
    end
    checkOutput("t4_iterations", iter, 10);
    drainAll("t4");

    // Reset asserted while a write is outstanding with three entries
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'hf, 32'h1faf_f300 + 4 * i, 32'hbbbb_0000 + i, 0, 0);
      endCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5_in_wr", dnWrReq, 1);
    resetn = 1'b0;
    #1;
    checkOutput("t5_rst_dn_wr_req", dnWrReq, 0);
    checkOutput("t5_rst_wr_ready", upWrReady, 1);
    checkOutput("t5_rst_empty", empty, 1);
    checkOutput("t5_rst_dn_wr_fields", {dnWrWstrb, dnWrAddr, dnWrData}, 0);
    expQ.delete();
    loadPending = 1'b0;
    prevRdReq   = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    endCycle();
    checkOutput("t5_empty_after", empty, 1);
    checkOutput("t5_idle_after", dnWrReq | dnRdReq, 0);

    // Stray ack in IDLE, then a load into an empty buffer
    applyStimulus(0, 0, 0, 0, 1, 32'hcafe_f00d);
    checkOutput("t6_stray_up_reload", upReload, 0);
    endCycle();
    checkOutput("t6_empty", empty, 1);
    checkOutput("t6_no_req", dnWrReq | dnRdReq, 0);
    loadPending = 1'b1;
    loadAddr    = 32'h1faf_f010;
    applyStimulus(0, 0, 0, 0, 0, 0);
    endCycle();
    checkOutput("t6_rd_latency", dnRdReq, 1);
    checkOutput("t6_rd_addr", dnRdAddr, 32'h1faf_f010);
    drainAll("t6");

    // Random traffic with a randomly delayed downstream responder
    for (int n = 0; n < 800; n++) begin
      if (!loadPending && ($urandom % 10 == 0)) begin
        loadPending = 1'b1;
        loadAddr    = $urandom;
      end
      reload = (dnWrReq | dnRdReq) && ($urandom % 3 == 0);
      applyStimulus($urandom % 3 == 0, 4'($urandom), $urandom, $urandom, reload, $urandom);
      endCycle();
    end
    drainAll("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case any loop above fails to make progress.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uncache_wbuf.md
# uncache_wbuf

Posted-write buffer for uncached (MMIO/conf) accesses, sitting directly downstream of `uncache` and upstream of `axi_ctrl`'s uncached port. Uncached stores are absorbed into a small FIFO and retired to `axi_ctrl` one at a time, so the core stalls only when the buffer is full. Uncached loads are strictly ordered behind all buffered stores and forwarded to `axi_ctrl` as single reads.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `PTR_W`, $clog2(DEPTH): pointer width; count is PTR_W+1 bits.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `up_wr_req` in 1: uncached store from `uncache`; accepted when `up_wr_ready`=1.
- `up_wr_wstrb` in 4: byte strobes.
- `up_wr_addr` in 32: physical address.
- `up_wr_data` in 32: store data.
- `up_wr_ready` out 1: buffer not full; 0 means upstream stalls.
- `up_rd_req` in 1: uncached load; held high until `up_reload`.
- `up_rd_addr` in 32: load address, stable while `up_rd_req`=1.
- `up_reload` out 1: one-cycle load completion pulse.
- `up_rd_data` out 32: load data, valid when `up_reload`=1.
- `dn_wr_req` out 1: write request to `axi_ctrl`.
- `dn_wr_wstrb` out 4: head-entry strobes.
- `dn_wr_addr` out 32: head-entry address.
- `dn_wr_data` out 32: head-entry data.
- `dn_rd_req` out 1: read request to `axi_ctrl`.
- `dn_rd_addr` out 32: read address.
- `dn_reload` in 1: one-cycle completion pulse from `axi_ctrl`, for the outstanding write or read.
- `dn_rd_data` in 32: read data, valid with `dn_reload` in RD.
- `empty` out 1: FIFO empty and FSM in IDLE.

## Operation
- FIFO of {wstrb, addr, data}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- Push: `up_wr_req & up_wr_ready`. Pop: `dn_reload` while in WR.
- `up_wr_ready` = (count != DEPTH). It is derived from registered count only and does not look ahead at a same-cycle pop.
- Simultaneous push and pop: count unchanged, both pointers advance.
- FSM states: IDLE, WR, RD.
  - IDLE → WR when count > 0. Writes take priority, so loads are never reordered ahead of stores.
  - IDLE → RD when count == 0 and `up_rd_req`.
  - WR → IDLE on `dn_reload`, which also pops the head.
  - RD → IDLE on `dn_reload`.
- `dn_wr_req` = (state == WR). `dn_wr_*` present the head entry and stay stable throughout WR.
- `dn_rd_req` = (state == RD). `dn_rd_addr` is registered from `up_rd_addr` on the IDLE→RD transition.
- `up_reload` = (state == RD) & `dn_reload`. `up_rd_data` = `dn_rd_data`, passed through combinationally.
- `dn_reload` outside WR/RD is ignored.
- No store-to-load forwarding and no write merging. MMIO semantics require every store to be issued exactly once, in order.

## Timing
- Reset values: `up_wr_ready`=1, `empty`=1; all other outputs 0. FSM=IDLE, pointers and count=0.
- Reset mid-transaction discards all entries and any in-flight request. `axi_ctrl` shares `resetn`.
- Store latency: push in cycle N to an empty IDLE buffer gives `dn_wr_req`=1 in cycle N+1.
- Every request is followed by at least one IDLE cycle: request drops the cycle after `dn_reload`, and the next request rises the cycle after that.
- Load behind k buffered stores: `dn_rd_req` rises 2 cycles after the k-th store's `dn_reload`. With an empty buffer it rises 1 cycle after `up_rd_req`.
- Full: the push in the cycle count reaches DEPTH is accepted. `up_wr_ready`=0 from the next cycle until the cycle after a pop.

## Structure
- Put these in `lib/defines.vh`:
  - FSM state encodings (IDLE=2'd0, WR=2'd1, RD=2'd2).
  - Entry width constant (68 bits).
- One natural sub-module, `wbuf_fifo`: a parameterised register-array FIFO exposing push, pop, head, count, full and empty. `uncache_wbuf` holds the FSM and the downstream and upstream handshakes.

## Test plan
- Single store: push {0x1faf_f000, 0xdead_beef, 4'hf}. Expect `dn_wr_req`=1 with those fields the next cycle. Drive `dn_reload` 3 cycles later; expect `dn_wr_req`=0 and `empty`=1 the following cycle.
- Fill: 5 back-to-back stores with DEPTH=4 and no `dn_reload`. Expect 4 accepted, `up_wr_ready`=0 on cycle 5, fifth store held. Pop once; expect fifth accepted, then drain order 1..5 exactly.
- Ordering: 2 stores then `up_rd_req` to 0x1faf_f008. Expect `dn_rd_req` only after both write `dn_reload`s, and `up_reload` with `up_rd_data`=0x1234_5678 the same cycle as the read's `dn_reload`.
- Push and pop in the same cycle at count=2: count stays 2, pointers wrap correctly past DEPTH-1 over 10 iterations.
- Reset asserted during WR with 3 entries: all outputs take reset values immediately, and `empty`=1 after release.
- Stray `dn_reload` in IDLE: no pop, no `up_reload`.
